// File: rtl/cache_pkg.sv
// Purpose: shared types and constants for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

  // Controller phases: serve hits, write back a dirty victim, refill a line.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_e;

  // funct3 access-size encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/mem_align.sv
// Purpose: load lane select + sign/zero extend, and store byte-merge into a word.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the cache line word is presented.
//
// Ports:
//   i_funct3  access size/sign (B, H, W, BU, HU)
//   i_offset  byte address bits [1:0]
//   i_rword   current 32-bit word from the cache line
//   i_wdata   right-aligned store data
//   o_rdata   extended load result
//   o_wword   i_rword with the store lanes replaced
module mem_align
  import cache_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane uses only addr[1]; addr[0] is ignored (no misalignment trap).
  always_comb begin
    w_byte = i_rword[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_rdata = i_rword;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'b0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'b0, w_half};
      F3_W:    o_rdata = i_rword;
      default: o_rdata = i_rword;
    endcase
  end

  always_comb begin
    o_wword = i_rword;
    case (i_funct3)
      F3_B, F3_BU: o_wword[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      F3_H, F3_HU: begin
        if (i_offset[1]) o_wword[31:16] = i_wdata[15:0];
        else             o_wword[15:0]  = i_wdata[15:0];
      end
      default:     o_wword = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Purpose: direct-mapped write-back data cache for the M stage, one-word backing bus.
// Latency: hits answer combinationally; a miss stalls for all transfer cycles + 1.
// Backpressure: StallM freezes the core; backing memory paces each word with MemAck.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   ReqM, MemWriteM, AddressingControlM, ALUResultM, WriteDataM   core request
//   RDM, StallM                      load data, pipeline stall
//   MemReq, MemWe, MemAddr, MemWData, MemRData, MemAck            backing memory
module data_cache
  import cache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  AddressingControlM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] RDM,
  output logic        StallM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  localparam int WI   = $clog2(LINE_WORDS);
  localparam int SI   = $clog2(SETS);
  localparam int TAGW = 32 - 2 - WI - SI;
  localparam logic [WI-1:0] LAST = WI'(LINE_WORDS - 1);

  // Storage: plain registers; data/tag are not reset, valid/dirty are.
  logic [31:0]     r_data  [SETS][LINE_WORDS];
  logic [TAGW-1:0] r_tag   [SETS];
  logic [SETS-1:0] r_valid;
  logic [SETS-1:0] r_dirty;

  state_e          r_state;
  state_e          w_next;
  logic [WI-1:0]   r_cnt;

  logic [WI-1:0]   w_word;
  logic [SI-1:0]   w_set;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic            w_idle;
  logic            w_last;
  logic            w_xfer_ack;
  logic            w_refill_done;
  logic            w_store_hit;
  logic [31:0]     w_line_word;
  logic [31:0]     w_load;
  logic [31:0]     w_merged;

  assign w_word = ALUResultM[2 +: WI];
  assign w_set  = ALUResultM[2 + WI +: SI];
  assign w_tag  = ALUResultM[31 -: TAGW];

  assign w_idle        = (r_state == S_IDLE);
  assign w_hit         = ReqM & r_valid[w_set] & (r_tag[w_set] == w_tag);
  assign w_last        = (r_cnt == LAST);
  // Acks are only meaningful while a transfer phase owns the bus.
  assign w_xfer_ack    = MemAck & ~w_idle;
  assign w_refill_done = (r_state == S_REFILL) & MemAck & w_last;
  assign w_store_hit   = w_idle & w_hit & MemWriteM;
  assign w_line_word   = r_data[w_set][w_word];

  mem_align u_align (
    .i_funct3 (AddressingControlM),
    .i_offset (ALUResultM[1:0]),
    .i_rword  (w_line_word),
    .i_wdata  (WriteDataM),
    .o_rdata  (w_load),
    .o_wword  (w_merged)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ReqM && !w_hit)
          w_next = (r_valid[w_set] && r_dirty[w_set]) ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: if (MemAck && w_last) w_next = S_REFILL;
      S_REFILL:    if (MemAck && w_last) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. The held request's own tag addresses the refill; the
  // stored victim tag addresses the writeback.
  always_comb begin
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = {w_tag, w_set, r_cnt, 2'b00};
    MemWData = r_data[w_set][r_cnt];
    StallM   = 1'b0;
    RDM      = '0;
    case (r_state)
      S_IDLE: begin
        // Reset gating keeps StallM low while rst is held even with ReqM up.
        StallM = rst & ReqM & ~w_hit;
        if (w_hit && !MemWriteM) RDM = w_load;
      end
      S_WRITEBACK: begin
        MemReq  = 1'b1;
        MemWe   = 1'b1;
        MemAddr = {r_tag[w_set], w_set, r_cnt, 2'b00};
        StallM  = 1'b1;
      end
      S_REFILL: begin
        MemReq = 1'b1;
        StallM = 1'b1;
      end
      default: ;
    endcase
  end

  // Word counter and line status bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_xfer_ack) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_refill_done) begin
        r_valid[w_set] <= 1'b1;
        r_dirty[w_set] <= 1'b0;
      end else if (w_store_hit) begin
        r_dirty[w_set] <= 1'b1;
      end
    end
  end

  // Data and tag arrays. During reset the FSM sits in IDLE with all lines
  // invalid, so none of these write enables can fire.
  always_ff @(posedge clk) begin
    if ((r_state == S_REFILL) && MemAck)
      r_data[w_set][r_cnt] <= MemRData;
    else if (w_store_hit)
      r_data[w_set][w_word] <= w_merged;
    if (w_refill_done)
      r_tag[w_set] <= w_tag;
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  AddressingControlM = F3_W;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] RDM;
  logic        StallM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  xact_t       log_q[$];
  logic [31:0] mem [logic [31:0]];
  int          mcnt = 0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk                (clk),
    .rst                (rst),
    .ReqM               (ReqM),
    .MemWriteM          (MemWriteM),
    .AddressingControlM (AddressingControlM),
    .ALUResultM         (ALUResultM),
    .WriteDataM         (WriteDataM),
    .RDM                (RDM),
    .StallM             (StallM),
    .MemReq             (MemReq),
    .MemWe              (MemWe),
    .MemAddr            (MemAddr),
    .MemWData           (MemWData),
    .MemRData           (MemRData),
    .MemAck             (MemAck)
  );

  // Backing memory: each word acks on the third cycle its request is held.
  always @(negedge clk) begin
    if (MemReq) begin
      mcnt = mcnt + 1;
      if (mcnt == 3) begin
        mcnt = 0;
        MemAck = 1'b1;
        if (MemWe) begin
          mem[MemAddr] = MemWData;
          log_q.push_back({1'b1, MemAddr, MemWData});
        end else begin
          MemRData = mem.exists(MemAddr) ? mem[MemAddr] : 32'h0;
          log_q.push_back({1'b0, MemAddr, MemRData});
        end
      end else begin
        MemAck = 1'b0;
      end
    end else begin
      mcnt = 0;
      MemAck = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a new request 2 time units after a rising edge; sample 1 unit later.
  task automatic go(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata);
    @(posedge clk);
    #2;
    ReqM = 1'b1;
    MemWriteM = we;
    AddressingControlM = f3;
    ALUResultM = addr;
    WriteDataM = wdata;
    #1;
  endtask

  // Count stalled cycles (including the current one); bounded.
  task automatic wait_stall(output int n);
    n = 0;
    while (StallM === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #3;
    end
  endtask

  task automatic check_reads(input string tag, input logic [31:0] base, input int first);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_we%0d", tag, i), {31'b0, log_q[first+i].we}, 32'h0);
      check($sformatf("%s_addr%0d", tag, i), log_q[first+i].addr, base + 32'(4*i));
    end
  endtask

  initial begin
    int n;
    logic [31:0] wb_exp [4];

    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;
    mem[32'h10C] = 32'h44;
    mem[32'h500] = 32'hA0;
    mem[32'h504] = 32'hA1;
    mem[32'h508] = 32'hA2;
    mem[32'h50C] = 32'hA3;

    // Reset held with a request pending: no stall, no bus activity.
    @(posedge clk);
    #2;
    ReqM = 1'b1;
    AddressingControlM = F3_W;
    ALUResultM = 32'h100;
    #1;
    check("rst_stall", {31'b0, StallM}, 32'h0);
    check("rst_memreq", {31'b0, MemReq}, 32'h0);
    check("rst_memwe", {31'b0, MemWe}, 32'h0);

    // Cold LW 0x100: same-cycle stall, 4 refill reads, 13 stall cycles.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("miss_stall_now", {31'b0, StallM}, 32'h1);
    check("miss_idle_memreq", {31'b0, MemReq}, 32'h0);
    wait_stall(n);
    check("cold_stall_cycles", n, 32'd13);
    check("cold_rdm", RDM, 32'h11);
    check("cold_nreads", log_q.size(), 32'd4);
    check_reads("cold", 32'h100, 0);

    // Hit on the refilled line.
    log_q.delete();
    go(1'b0, F3_W, 32'h108, 32'h0);
    check("hit_rdm", RDM, 32'h33);
    check("hit_stall", {31'b0, StallM}, 32'h0);
    check("hit_memreq", {31'b0, MemReq}, 32'h0);

    // SB then signed/unsigned byte loads.
    go(1'b1, F3_B, 32'h101, 32'hFF);
    check("sb_stall", {31'b0, StallM}, 32'h0);
    go(1'b0, F3_B, 32'h101, 32'h0);
    check("lb_rdm", RDM, 32'hFFFFFFFF);
    go(1'b0, F3_BU, 32'h101, 32'h0);
    check("lbu_rdm", RDM, 32'h000000FF);
    go(1'b0, F3_W, 32'h100, 32'h0);
    check("lw_after_sb", RDM, 32'h0000FF11);
    check("no_bus_on_hits", log_q.size(), 32'd0);

    // Conflict miss on a dirty line: writeback then refill.
    go(1'b0, F3_W, 32'h500, 32'h0);
    check("conf_stall_now", {31'b0, StallM}, 32'h1);
    wait_stall(n);
    check("conf_stall_cycles", n, 32'd25);
    check("conf_rdm", RDM, 32'hA0);
    check("conf_nxacts", log_q.size(), 32'd8);
    wb_exp[0] = 32'h0000FF11;
    wb_exp[1] = 32'h22;
    wb_exp[2] = 32'h33;
    wb_exp[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wb_we%0d", i), {31'b0, log_q[i].we}, 32'h1);
      check($sformatf("wb_addr%0d", i), log_q[i].addr, 32'h100 + 32'(4*i));
      check($sformatf("wb_data%0d", i), log_q[i].data, wb_exp[i]);
    end
    check_reads("conf", 32'h500, 4);

    // Refilled line is clean: evicting it refills without writeback.
    log_q.delete();
    go(1'b0, F3_W, 32'h100, 32'h0);
    wait_stall(n);
    check("clean_stall_cycles", n, 32'd13);
    check("clean_rdm", RDM, 32'h0000FF11);
    check("clean_nxacts", log_q.size(), 32'd4);
    check_reads("clean", 32'h100, 0);

    // Halfword lanes, addr[0] ignored; word store ignores addr[1:0].
    go(1'b1, F3_H, 32'h102, 32'hBEEF);
    go(1'b0, F3_H, 32'h102, 32'h0);
    check("lh_rdm", RDM, 32'hFFFFBEEF);
    go(1'b0, F3_HU, 32'h103, 32'h0);
    check("lhu_rdm", RDM, 32'h0000BEEF);
    go(1'b0, F3_W, 32'h100, 32'h0);
    check("lw_after_sh", RDM, 32'hBEEFFF11);
    go(1'b1, F3_W, 32'h10F, 32'h12345678);
    go(1'b0, F3_W, 32'h10C, 32'h0);
    check("sw_unaligned", RDM, 32'h12345678);

    // No request: idle, no stall, zero data.
    @(posedge clk);
    #2;
    ReqM = 1'b0;
    #1;
    check("noreq_stall", {31'b0, StallM}, 32'h0);
    check("noreq_rdm", RDM, 32'h0);

    // Reset in the middle of a refill abandons it; dirty data is lost.
    log_q.delete();
    go(1'b0, F3_W, 32'h200, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    check("refill_memreq", {31'b0, MemReq}, 32'h1);
    check("refill_memwe", {31'b0, MemWe}, 32'h0);
    check("refill_addr", MemAddr, 32'h200);
    rst = 1'b0;
    #1;
    check("rstmid_memreq", {31'b0, MemReq}, 32'h0);
    check("rstmid_stall", {31'b0, StallM}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    ALUResultM = 32'h100;
    #1;
    check("post_rst_miss", {31'b0, StallM}, 32'h1);
    wait_stall(n);
    check("post_rst_cycles", n, 32'd13);
    check("post_rst_rdm", RDM, 32'h0000FF11);

    @(posedge clk);
    #2;
    ReqM = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
